// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcode/funct values,
// controller states, ALU operation selector and the ALU datapath function.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB} state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

    // Wrap-around arithmetic; shifts act on b by the shamt field.
    function automatic logic [31:0] alu_compute(alu_op_t op, logic [31:0] a,
                                                logic [31:0] b, logic [4:0] shamt);
        logic [31:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'd0, a < b};
            ALU_SLL:  r = b << shamt;
            ALU_SRL:  r = b >> shamt;
            ALU_SRA:  r = 32'($signed(b) >>> shamt);
            ALU_LUI:  r = {b[15:0], 16'h0000};
            default:  r = 32'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file: two operand read ports, one debug
// read port (all combinational) and a single enabled write port. $0 is a
// constant zero, so writes to it simply have nowhere to land.
module mips_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        clk_en,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    output logic [31:0] dbg_data
);

    logic [31:0] gpr [32];

    assign gpr[0] = 32'd0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            logic [31:0] q_reg;
            // One storage word per register; reset wins over a pending write.
            always_ff @(posedge clk) begin
                if (srst)
                    q_reg <= 32'd0;
                else if (clk_en && we && (waddr == 5'(gi)))
                    q_reg <= wdata;
            end
            assign gpr[gi] = q_reg;
        end
    endgenerate

    assign rdata_a  = gpr[raddr_a];
    assign rdata_b  = gpr[raddr_b];
    assign dbg_data = gpr[dbg_addr];

endmodule

// File: rtl/mips_multicycle_cpu.sv
// Multi-cycle MIPS-subset core on one unified memory port. Each instruction
// walks FETCH -> DECODE -> EXECUTE [-> MEM] [-> WB]; nothing moves unless
// clk_en is high, except reset.
module mips_multicycle_cpu
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_100M,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [31:0] r_data,
    output logic        wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] w_data,
    input  logic [4:0]  rdbg_addr,
    output logic [31:0] rdbg_data,
    output logic [31:0] instr
);

    state_t      state_reg;
    logic [31:0] pc_reg, ir_reg, a_reg, b_reg, alu_out_reg, mdr_reg;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_sext, imm_zext;

    assign opcode   = ir_reg[31:26];
    assign rs       = ir_reg[25:21];
    assign rt       = ir_reg[20:16];
    assign rd       = ir_reg[15:11];
    assign shamt    = ir_reg[10:6];
    assign funct    = ir_reg[5:0];
    assign imm_sext = {{16{ir_reg[15]}}, ir_reg[15:0]};
    assign imm_zext = {16'h0000, ir_reg[15:0]};

    logic [31:0] rs_val, rt_val;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    alu_op_t     alu_op;
    logic [31:0] alu_b, alu_result;
    logic        alu_valid;
    logic [4:0]  dest;

    // Map opcode/funct to an ALU operation, its second operand and the
    // destination register; anything unrecognised leaves alu_valid low.
    always_comb begin
        alu_op    = ALU_ADD;
        alu_b     = b_reg;
        alu_valid = 1'b1;
        dest      = rt;
        if (opcode == OP_RTYPE) begin
            dest = rd;
            case (funct)
                FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                FN_AND:          alu_op = ALU_AND;
                FN_OR:           alu_op = ALU_OR;
                FN_XOR:          alu_op = ALU_XOR;
                FN_NOR:          alu_op = ALU_NOR;
                FN_SLT:          alu_op = ALU_SLT;
                FN_SLTU:         alu_op = ALU_SLTU;
                FN_SLL:          alu_op = ALU_SLL;
                FN_SRL:          alu_op = ALU_SRL;
                FN_SRA:          alu_op = ALU_SRA;
                default:         alu_valid = 1'b0;
            endcase
        end else begin
            case (opcode)
                OP_ADDI, OP_ADDIU: begin alu_op = ALU_ADD;  alu_b = imm_sext; end
                OP_SLTI:           begin alu_op = ALU_SLT;  alu_b = imm_sext; end
                OP_SLTIU:          begin alu_op = ALU_SLTU; alu_b = imm_sext; end
                OP_ANDI:           begin alu_op = ALU_AND;  alu_b = imm_zext; end
                OP_ORI:            begin alu_op = ALU_OR;   alu_b = imm_zext; end
                OP_XORI:           begin alu_op = ALU_XOR;  alu_b = imm_zext; end
                OP_LUI:            begin alu_op = ALU_LUI;  alu_b = imm_zext; end
                default:           alu_valid = 1'b0;
            endcase
        end
    end

    assign alu_result = alu_compute(alu_op, a_reg, alu_b, shamt);

    // Register write-back: WB stage for ALU/lw results, EXECUTE for jal's link.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (state_reg == WB) begin
            rf_we    = 1'b1;
            rf_waddr = dest;
            rf_wdata = (opcode == OP_LW) ? mdr_reg : alu_out_reg;
        end else if (state_reg == EXECUTE && opcode == OP_JAL) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_reg;
        end
    end

    mips_regfile u_regfile (
        .clk      (clk_100M),
        .srst     (rst),
        .clk_en   (clk_en),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr_a  (rs),
        .raddr_b  (rt),
        .dbg_addr (rdbg_addr),
        .rdata_a  (rs_val),
        .rdata_b  (rt_val),
        .dbg_data (rdbg_data)
    );

    // Controller and datapath registers; pc_reg already holds instr addr+4
    // by EXECUTE, which is the base for branch targets and the jal link.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_reg   <= FETCH;
            pc_reg      <= RESET_PC;
            ir_reg      <= 32'd0;
            a_reg       <= 32'd0;
            b_reg       <= 32'd0;
            alu_out_reg <= 32'd0;
            mdr_reg     <= 32'd0;
        end else if (clk_en) begin
            case (state_reg)
                FETCH: begin
                    ir_reg    <= r_data;
                    pc_reg    <= pc_reg + 32'd4;
                    state_reg <= DECODE;
                end
                DECODE: begin
                    a_reg     <= rs_val;
                    b_reg     <= rt_val;
                    state_reg <= EXECUTE;
                end
                EXECUTE: begin
                    state_reg <= FETCH;
                    if (opcode == OP_LW || opcode == OP_SW) begin
                        alu_out_reg <= a_reg + imm_sext;
                        state_reg   <= MEM;
                    end else if (alu_valid) begin
                        alu_out_reg <= alu_result;
                        state_reg   <= WB;
                    end else begin
                        case (opcode)
                            OP_BEQ: if (a_reg == b_reg)
                                        pc_reg <= pc_reg + {imm_sext[29:0], 2'b00};
                            OP_BNE: if (a_reg != b_reg)
                                        pc_reg <= pc_reg + {imm_sext[29:0], 2'b00};
                            OP_J, OP_JAL:
                                pc_reg <= {pc_reg[31:28], ir_reg[25:0], 2'b00};
                            OP_RTYPE: if (funct == FN_JR)
                                        pc_reg <= a_reg;
                            default: ;
                        endcase
                    end
                end
                MEM: begin
                    if (opcode == OP_LW) begin
                        mdr_reg   <= r_data;
                        state_reg <= WB;
                    end else begin
                        state_reg <= FETCH;
                    end
                end
                WB:      state_reg <= FETCH;
                default: state_reg <= FETCH;
            endcase
        end
    end

    assign mem_addr = (state_reg == MEM) ? alu_out_reg : pc_reg;
    assign w_data   = b_reg;
    assign wr_en    = (state_reg == MEM) && (opcode == OP_SW);
    assign instr    = ir_reg;

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Bench for mips_multicycle_cpu: directed programs plus random programs,
// checked per cycle and per instruction against an instruction-level model.
module tb_mips_multicycle_cpu;

    logic        clk_100M = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b0;
    logic [31:0] r_data;
    logic        wr_en;
    logic [31:0] mem_addr, w_data;
    logic [4:0]  rdbg_addr = 5'd0;
    logic [31:0] rdbg_data, instr;

    logic [31:0] ram     [256];
    logic [31:0] mdl_mem [256];
    logic [31:0] mdl_gpr [32];
    logic [31:0] mdl_pc;

    int n_cmp = 0;
    int n_bad = 0;

    int r_fns[13] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B, 'h00, 'h02, 'h03};
    int i_ops[8]  = '{'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F};

    mips_multicycle_cpu #(.RESET_PC(32'h0000_0000)) dut (
        .clk_100M  (clk_100M),
        .rst       (rst),
        .clk_en    (clk_en),
        .r_data    (r_data),
        .wr_en     (wr_en),
        .mem_addr  (mem_addr),
        .w_data    (w_data),
        .rdbg_addr (rdbg_addr),
        .rdbg_data (rdbg_data),
        .instr     (instr)
    );

    always #5 clk_100M = ~clk_100M;

    assign r_data = ram[mem_addr[9:2]];

    always @(posedge clk_100M)
        if (clk_en && wr_en) ram[mem_addr[9:2]] <= w_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd, int sh);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] enc_j(int op, int tgt);
        return {op[5:0], tgt[25:0]};
    endfunction

    task automatic set_word(input int idx, input logic [31:0] w);
        ram[idx]     = w;
        mdl_mem[idx] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) set_word(i, 32'd0);
    endtask

    task automatic chk_reg(input string tag, input int r, input logic [31:0] exp);
        clk_en    = 1'b0;
        rdbg_addr = r[4:0];
        #1;
        check(tag, rdbg_data, exp);
    endtask

    task automatic do_reset();
        @(negedge clk_100M);
        rst = 1'b1;
        clk_en = 1'b0;
        @(negedge clk_100M);
        @(negedge clk_100M);
        rst = 1'b0;
        for (int r = 0; r < 32; r++) mdl_gpr[r] = 32'd0;
        mdl_pc = 32'd0;
        #1;
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_instr", instr, 32'd0);
    endtask

    // Execute one instruction on the model, then drive the DUT through the
    // matching number of enabled cycles while checking the memory port.
    task automatic run_instr(input bit rnd_en, input int freeze_at);
        logic [31:0] w, a, b, sx, zx, res, ea, npc, pc4;
        logic [31:0] snap_a, snap_d, snap_i;
        logic        snap_w;
        int op, fn, rs, rt, rd, sh, dst, ncyc, k, guard;
        bit is_sw, is_lw, wr, frozen;
        w  = mdl_mem[mdl_pc[9:2]];
        op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sh = w[10:6]; fn = w[5:0];
        a  = mdl_gpr[rs]; b = mdl_gpr[rt];
        sx = {{16{w[15]}}, w[15:0]};
        zx = {16'h0000, w[15:0]};
        pc4 = mdl_pc + 32'd4; npc = pc4;
        ncyc = 3; wr = 0; dst = 0; res = 0; is_sw = 0; is_lw = 0; ea = 0; frozen = 0;
        case (op)
            'h00: begin
                ncyc = 4; wr = 1; dst = rd;
                case (fn)
                    'h20, 'h21: res = a + b;
                    'h22, 'h23: res = a - b;
                    'h24: res = a & b;
                    'h25: res = a | b;
                    'h26: res = a ^ b;
                    'h27: res = ~(a | b);
                    'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    'h2B: res = (a < b) ? 32'd1 : 32'd0;
                    'h00: res = b << sh;
                    'h02: res = b >> sh;
                    'h03: res = $signed(b) >>> sh;
                    'h08: begin ncyc = 3; wr = 0; npc = a; end
                    default: begin ncyc = 3; wr = 0; end
                endcase
            end
            'h02: npc = {pc4[31:28], w[25:0], 2'b00};
            'h03: begin npc = {pc4[31:28], w[25:0], 2'b00}; wr = 1; dst = 31; res = pc4; end
            'h04: if (a == b) npc = pc4 + sx * 4;
            'h05: if (a != b) npc = pc4 + sx * 4;
            'h08, 'h09: begin ncyc = 4; wr = 1; dst = rt; res = a + sx; end
            'h0A: begin ncyc = 4; wr = 1; dst = rt; res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; end
            'h0B: begin ncyc = 4; wr = 1; dst = rt; res = (a < sx) ? 32'd1 : 32'd0; end
            'h0C: begin ncyc = 4; wr = 1; dst = rt; res = a & zx; end
            'h0D: begin ncyc = 4; wr = 1; dst = rt; res = a | zx; end
            'h0E: begin ncyc = 4; wr = 1; dst = rt; res = a ^ zx; end
            'h0F: begin ncyc = 4; wr = 1; dst = rt; res = w[15:0] * 32'h10000; end
            'h23: begin ncyc = 5; is_lw = 1; ea = a + sx; wr = 1; dst = rt; res = mdl_mem[ea[9:2]]; end
            'h2B: begin ncyc = 4; is_sw = 1; ea = a + sx; end
            default: ;
        endcase

        k = 0; guard = 0;
        while (k < ncyc && guard < 400) begin
            @(negedge clk_100M);
            if (k == freeze_at && !frozen) begin
                frozen = 1;
                clk_en = 1'b0;
                #1;
                snap_a = mem_addr; snap_w = wr_en; snap_d = w_data; snap_i = instr;
                repeat (5) begin
                    @(negedge clk_100M);
                    #1;
                    check("frz_mem_addr", mem_addr, snap_a);
                    check("frz_wr_en", {31'd0, wr_en}, {31'd0, snap_w});
                    check("frz_w_data", w_data, snap_d);
                    check("frz_instr", instr, snap_i);
                end
            end
            clk_en = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (clk_en) begin
                if (k == 0) check("fetch_addr", mem_addr, mdl_pc);
                if (k == 1) check("instr", instr, w);
                check("wr_en", {31'd0, wr_en}, {31'd0, (is_sw && k == 3)});
                if ((is_sw || is_lw) && k == 3) check("mem_ea", mem_addr, ea);
                if (is_sw && k == 3) check("w_data", w_data, b);
                k++;
            end
            guard++;
        end
        if (k < ncyc) check("cycle_budget", 32'(k), 32'(ncyc));

        if (wr && dst != 0) mdl_gpr[dst] = res;
        if (is_sw) mdl_mem[ea[9:2]] = b;
        mdl_pc = npc;

        @(negedge clk_100M);
        clk_en = 1'b0;
        #1;
        check("next_pc", mem_addr, mdl_pc);
        if (wr) chk_reg("dest_reg", dst, mdl_gpr[dst]);
        if (is_sw) check("ram_store", ram[ea[9:2]], mdl_mem[ea[9:2]]);
        $display("instr pc=%08h word=%08h next=%08h cycles=%0d", pc4 - 32'd4, w, mdl_pc, ncyc);
    endtask

    task automatic gen_random_program();
        int kind, pick;
        clear_mem();
        for (int i = 0; i < 112; i++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1: begin
                    pick = $urandom_range(0, 12);
                    set_word(i, enc_r(r_fns[pick], $urandom_range(0, 7), $urandom_range(0, 7),
                                      $urandom_range(0, 7), $urandom_range(0, 31)));
                end
                2, 3, 4, 9: begin
                    pick = $urandom_range(0, 7);
                    set_word(i, enc_i(i_ops[pick], $urandom_range(0, 7), $urandom_range(0, 7),
                                      $urandom_range(0, 65535)));
                end
                5: set_word(i, enc_i('h23, 0, $urandom_range(0, 7), 'h200 + 4 * $urandom_range(0, 127)));
                6: set_word(i, enc_i('h2B, 0, $urandom_range(0, 7), 'h200 + 4 * $urandom_range(0, 127)));
                7: set_word(i, enc_i($urandom_range(4, 5), $urandom_range(0, 7), $urandom_range(0, 7),
                                     $urandom_range(0, 3)));
                default: begin
                    if ($urandom_range(0, 1) == 0) set_word(i, enc_i('h3F, 1, 2, 3));
                    else                           set_word(i, enc_r('h3F, 1, 2, 3, 0));
                end
            endcase
        end
        for (int i = 128; i < 256; i++) set_word(i, $urandom);
    endtask

    initial begin
        int steps;

        // Program 1: arithmetic, store/load, $0 write, signed/unsigned compare, overflow wrap.
        clear_mem();
        set_word(0,  enc_i('h08, 0, 1, 5));
        set_word(1,  enc_i('h08, 0, 2, 'h40));
        set_word(2,  enc_i('h2B, 2, 1, 0));
        set_word(3,  enc_i('h23, 2, 3, 0));
        set_word(4,  enc_i('h08, 0, 0, 7));
        set_word(5,  enc_i('h08, 0, 4, 'hFFFF));
        set_word(6,  enc_i('h08, 0, 5, 1));
        set_word(7,  enc_r('h2A, 4, 5, 6, 0));
        set_word(8,  enc_r('h2B, 4, 5, 7, 0));
        set_word(9,  enc_i('h0F, 0, 8, 'h7FFF));
        set_word(10, enc_i('h0D, 8, 8, 'hFFFF));
        set_word(11, enc_r('h20, 8, 5, 9, 0));
        do_reset();
        for (int i = 0; i < 12; i++) run_instr(1'b0, (i == 2) ? 3 : -1);
        chk_reg("addi_r1", 1, 32'd5);
        chk_reg("lw_r3", 3, 32'd5);
        chk_reg("zero_r0", 0, 32'd0);
        chk_reg("slt_r6", 6, 32'd1);
        chk_reg("sltu_r7", 7, 32'd0);
        chk_reg("add_wrap_r9", 9, 32'h8000_0000);
        check("ram_0x40", ram[16], 32'd5);

        // Program 2a/2b: taken beq and not-taken bne at 0x10.
        for (int t = 0; t < 2; t++) begin
            clear_mem();
            set_word(0, enc_i('h08, 0, 1, 5));
            set_word(4, enc_i((t == 0) ? 'h04 : 'h05, 1, 1, 2));
            do_reset();
            for (int i = 0; i < 5; i++) run_instr(1'b0, -1);
            check((t == 0) ? "beq_target" : "bne_fallthru", mem_addr, (t == 0) ? 32'h1C : 32'h14);
        end

        // Program 3: jal to 0x40, then jr $31 back to 0xC.
        clear_mem();
        set_word(2,  enc_j('h03, 'h10));
        set_word(3,  enc_i('h08, 0, 2, 9));
        set_word(16, enc_r('h08, 31, 0, 0, 0));
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(1'b0, -1);
        check("jal_target", mem_addr, 32'h40);
        chk_reg("jal_link", 31, 32'hC);
        run_instr(1'b0, -1);
        check("jr_target", mem_addr, 32'hC);
        run_instr(1'b1, -1);

        // Reset in the cycle that would write back: the write must not land.
        clear_mem();
        set_word(0, enc_i('h08, 0, 1, 5));
        do_reset();
        repeat (3) begin
            @(negedge clk_100M);
            clk_en = 1'b1;
        end
        @(negedge clk_100M);
        rst = 1'b1;
        @(negedge clk_100M);
        rst = 1'b0;
        clk_en = 1'b0;
        #1;
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_instr", instr, 32'd0);
        chk_reg("abort_r1", 1, 32'd0);
        run_instr(1'b0, -1);
        chk_reg("after_abort_r1", 1, 32'd5);

        // Random programs with randomly gated clk_en.
        for (int p = 0; p < 3; p++) begin
            gen_random_program();
            do_reset();
            steps = 0;
            while (mdl_pc < 32'h1C0 && steps < 200) begin
                run_instr(1'b1, (steps == 10) ? 1 : -1);
                steps++;
            end
            for (int r = 0; r < 32; r++) chk_reg("final_reg", r, mdl_gpr[r]);
            for (int i = 128; i < 256; i++) check("final_ram", ram[i], mdl_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
